// File: rtl/alu_seq_if.sv
// alu_seq_if: start/busy/done handshake with operand and flagged-result bundle.
interface alu_seq_if #(parameter int W = 14);
  logic         start;
  logic [1:0]   op_sel;
  logic [W-1:0] op1, op2, res;
  logic         f_OF, f_sig_res, f_inv, busy, done;
  modport master(output start, op_sel, op1, op2, input res, f_OF, f_sig_res, f_inv, busy, done);
  modport slave(input start, op_sel, op1, op2, output res, f_OF, f_sig_res, f_inv, busy, done);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential add/sub/mul with range flags; multiply is radix-2 shift-add over W edges.
module alu_seq #(
  parameter int W       = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(W);
  localparam logic [2*W-1:0] MAXV = (2*W)'(MAX_VAL);
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
  state_t         r_state;
  logic [W-1:0]   r_a, r_b, r_res;
  logic [1:0]     r_op;
  logic           r_inv, r_of, r_sig, r_finv, r_busy, r_done;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           w_in_inv, w_ge, w_of, w_sig;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_res;
  assign w_in_inv = ((2*W)'(bus.op1) > MAXV) || ((2*W)'(bus.op2) > MAXV) || (bus.op_sel == 2'b11);
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_ge     = r_a >= r_b;
  assign w_of     = !r_inv && ((r_op == 2'b00 && (2*W)'(w_sum) > MAXV) || (r_op == 2'b10 && r_acc > MAXV));
  assign w_sig    = !r_inv && r_op == 2'b01 && !w_ge;
  assign w_res    = (r_inv || w_of) ? '0 :
                    (r_op == 2'b01) ? (w_ge ? r_a - r_b : r_b - r_a) :
                    (r_op == 2'b10) ? r_acc[W-1:0] : w_sum[W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_inv   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_of    <= 1'b0;
      r_sig   <= 1'b0;
      r_finv  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_a     <= bus.op1;
          r_b     <= bus.op2;
          r_op    <= bus.op_sel;
          r_inv   <= w_in_inv;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= (bus.op_sel == 2'b10 && !w_in_inv) ? MUL : FIN;
        end
        MUL: begin
          if (r_b[r_cnt]) r_acc <= r_acc + ((2*W)'(r_a) << r_cnt);
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(W-1)) r_state <= FIN;
        end
        FIN: begin
          r_res   <= w_res;
          r_of    <= w_of;
          r_sig   <= w_sig;
          r_finv  <= r_inv;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.res       = r_res;
  assign bus.f_OF      = r_of;
  assign bus.f_sig_res = r_sig;
  assign bus.f_inv     = r_finv;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule
